// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared width, op encodings and FSM states for the HI/LO multiply/divide unit.
//   MULDIV_WIDTH : operand and HI/LO width
//   op_e         : MULT/MULTU/DIV/DIVU encodings as issued by decode (bit1 = divide, bit0 = unsigned)
//   state_e      : sequencer states IDLE -> BUSY -> SIGN -> DONE
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiplier (see muldiv_ctrl).
package muldiv_ctrl_pkg;
   localparam int MULDIV_WIDTH = 32;
   typedef enum logic [1:0] {MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU} op_e;
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_SIGN, S_DONE} state_e;
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EXE-stage handshake and HI/LO result bundle for the multiply/divide unit.
//   master (EXE side): drives start_exe, op_exe, srca_exe, srcb_exe, mthi_exe, mtlo_exe, flush_exe;
//                      receives stall_exe, busy, done, hi, lo
//   slave  (muldiv_ctrl): the reverse directions
interface muldiv_ctrl_if
   import muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
);
   logic             start_exe;
   logic [1:0]       op_exe;
   logic [WIDTH-1:0] srca_exe;
   logic [WIDTH-1:0] srcb_exe;
   logic             mthi_exe;
   logic             mtlo_exe;
   logic             flush_exe;
   logic             stall_exe;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (
      output start_exe, op_exe, srca_exe, srcb_exe, mthi_exe, mtlo_exe, flush_exe,
      input  stall_exe, busy, done, hi, lo
   );
   modport slave (
      input  start_exe, op_exe, srca_exe, srcb_exe, mthi_exe, mtlo_exe, flush_exe,
      output stall_exe, busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide loop.
//   div_i  : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi_i   : partial product high half / partial remainder
//   lo_i   : multiplier bits still to consume / dividend bits shifting into quotient
//   opd_i  : multiplicand (multiply) or divisor (divide)
//   hi_o, lo_o : next values of hi_i/lo_i
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             div_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] opd_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   logic [WIDTH:0] sum, shl, diff;
   always_comb begin
      sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opd_i} : '0);
      shl  = {hi_i, lo_i[WIDTH-1]};
      // partial remainder stays below the divisor, so bit WIDTH of diff is a clean borrow
      diff = shl - {1'b0, opd_i};
      hi_o = div_i ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
      lo_o = div_i ? {lo_i[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_i[WIDTH-1:1]};
   end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer beside the EXE-stage ALU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_ctrl_if.slave -- start_exe/op_exe/srca_exe/srcb_exe/mthi_exe/mtlo_exe/flush_exe in,
//              stall_exe/busy/done/hi/lo out
// Iterative path: IDLE -> BUSY (STEPS cycles) -> SIGN -> DONE, 34 cycles start-to-done at WIDTH=32.
// Build option MULDIV_FAST_MUL_EN: MULT/MULTU finish in one cycle (IDLE -> DONE); divide unchanged.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH,
   parameter int STEPS = WIDTH
) (
   input logic          clk,
   input logic          rst,
   muldiv_ctrl_if.slave bus
);
   localparam int CW = $clog2(STEPS);
   state_e                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [WIDTH-1:0]       acc_hi_q, acc_lo_q, opd_q, hi_q, lo_q;
   logic [WIDTH-1:0]       acc_hi_d, acc_lo_d;
   logic                   div_q, neg_q, rneg_q, bz_q, done_q;
   logic                   mt, go, sgn_op, sa, sb;
   logic [WIDTH-1:0]       abs_a, abs_b, q_s, r_s;
   logic [2*WIDTH-1:0]     prod_s;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0]     fast_p;
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_i (div_q),
      .hi_i  (acc_hi_q),
      .lo_i  (acc_lo_q),
      .opd_i (opd_q),
      .hi_o  (acc_hi_d),
      .lo_o  (acc_lo_d)
   );

   always_comb begin
      mt     = bus.mthi_exe | bus.mtlo_exe;
      // an MT* write in IDLE takes priority, so start is not accepted alongside it
      go     = (state_q == S_IDLE) & bus.start_exe & ~bus.flush_exe & ~mt;
      sgn_op = ~bus.op_exe[0];
      sa     = sgn_op & bus.srca_exe[WIDTH-1];
      sb     = sgn_op & bus.srcb_exe[WIDTH-1];
      abs_a  = sa ? -bus.srca_exe : bus.srca_exe;
      abs_b  = sb ? -bus.srcb_exe : bus.srcb_exe;
      prod_s = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
      // divide by zero keeps an all-ones quotient regardless of operand signs
      q_s    = bz_q ? '1 : neg_q ? -acc_lo_q : acc_lo_q;
      r_s    = rneg_q ? -acc_hi_q : acc_hi_q;
`ifdef MULDIV_FAST_MUL_EN
      // sign- or zero-extend to 2*WIDTH so one unsigned multiply serves both MULT and MULTU
      fast_p = {{WIDTH{sa}}, bus.srca_exe} * {{WIDTH{sb}}, bus.srcb_exe};
`endif
   end

   assign bus.stall_exe = go | (state_q == S_BUSY) | (state_q == S_SIGN);
   assign bus.busy      = (state_q == S_BUSY) | (state_q == S_SIGN);
   assign bus.done      = done_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.mthi_exe) hi_q <= bus.srca_exe;
               if (bus.mtlo_exe) lo_q <= bus.srca_exe;
`ifdef MULDIV_FAST_MUL_EN
               if (go && !bus.op_exe[1]) begin
                  {hi_q, lo_q} <= fast_p;
                  done_q       <= 1'b1;
                  state_q      <= S_DONE;
               end else
`endif
               if (go) begin
                  div_q    <= bus.op_exe[1];
                  neg_q    <= sa ^ sb;
                  rneg_q   <= sa;
                  bz_q     <= bus.srcb_exe == '0;
                  acc_hi_q <= '0;
                  // multiply consumes the multiplier from lo; divide shifts the dividend out of lo
                  acc_lo_q <= bus.op_exe[1] ? abs_a : abs_b;
                  opd_q    <= bus.op_exe[1] ? abs_b : abs_a;
                  cnt_q    <= '0;
                  state_q  <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (bus.flush_exe) state_q <= S_IDLE;
               else begin
                  acc_hi_q <= acc_hi_d;
                  acc_lo_q <= acc_lo_d;
                  cnt_q    <= cnt_q + 1'b1;
                  if (cnt_q == CW'(STEPS - 1)) state_q <= S_SIGN;
               end
            end
            S_SIGN: begin
               if (bus.flush_exe) state_q <= S_IDLE;
               else begin
                  {hi_q, lo_q} <= div_q ? {r_s, q_s} : prod_s;
                  done_q       <= 1'b1;
                  state_q      <= S_DONE;
               end
            end
            S_DONE: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl (honours MULDIV_FAST_MUL_EN timing).
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   muldiv_ctrl_if bus ();
   muldiv_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion before 200000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op in cycle 0, hold it while stalled, check stall profile and committed HI/LO.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
      int lat;
      int bad;
      lat = 34;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) lat = 1;
`endif
      bad = 0;
      bus.start_exe = 1'b1;
      bus.op_exe    = op;
      bus.srca_exe  = a;
      bus.srcb_exe  = b;
      #1;
      chk($sformatf("%s stall c0", tag), 64'(bus.stall_exe), 64'd1);
      for (int c = 1; c < lat; c++) begin
         tick();
         if (bus.stall_exe !== 1'b1 || bus.done !== 1'b0) bad++;
      end
      chk($sformatf("%s stall profile", tag), 64'(bad), 64'd0);
      tick();
      chk($sformatf("%s done", tag), 64'(bus.done), 64'd1);
      chk($sformatf("%s stall at done", tag), 64'(bus.stall_exe), 64'd0);
      chk($sformatf("%s hi", tag), 64'(bus.hi), 64'(eh));
      chk($sformatf("%s lo", tag), 64'(bus.lo), 64'(el));
      bus.start_exe = 1'b0;
      tick();
      chk($sformatf("%s done pulse", tag), 64'(bus.done), 64'd0);
   endtask

   initial begin
      int seen;
      logic [1:0] fl_op;
      bus.start_exe = 1'b0;
      bus.op_exe    = 2'b00;
      bus.srca_exe  = '0;
      bus.srcb_exe  = '0;
      bus.mthi_exe  = 1'b0;
      bus.mtlo_exe  = 1'b0;
      bus.flush_exe = 1'b0;
      rst = 1'b1;
      tick();
      bus.mthi_exe = 1'b1;
      bus.mtlo_exe = 1'b1;
      bus.srca_exe = 32'hAAAA_5555;
      tick();
      chk("reset beats mt hi", 64'(bus.hi), 64'd0);
      chk("reset beats mt lo", 64'(bus.lo), 64'd0);
      bus.mthi_exe = 1'b0;
      bus.mtlo_exe = 1'b0;
      rst = 1'b0;
      #1;
      chk("reset done", 64'(bus.done), 64'd0);
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset stall", 64'(bus.stall_exe), 64'd0);

      run_op("mult -3*7",    MULDIV_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("divu 100/7",   MULDIV_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
      run_op("div -7/2",     MULDIV_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div 7/-2",     MULDIV_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
      run_op("div 5/0",      MULDIV_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
      run_op("div ovf",      MULDIV_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
      run_op("multu max",    MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("multu x2",     MULDIV_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE);
      run_op("mult -5*-6",   MULDIV_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0,         32'd30);

      // MTHI then MTLO in IDLE
      bus.mthi_exe = 1'b1;
      bus.srca_exe = 32'h0000_CAFE;
      tick();
      bus.mthi_exe = 1'b0;
      bus.mtlo_exe = 1'b1;
      bus.srca_exe = 32'h0000_1234;
      tick();
      bus.mtlo_exe = 1'b0;
      chk("mthi write", 64'(bus.hi), 64'h0000_CAFE);
      chk("mtlo write", 64'(bus.lo), 64'h0000_1234);

      // MT* together with start: write happens, start ignored
      bus.mtlo_exe  = 1'b1;
      bus.start_exe = 1'b1;
      bus.op_exe    = MULDIV_DIVU;
      bus.srca_exe  = 32'h0000_0055;
      bus.srcb_exe  = 32'd1;
      #1;
      chk("mt+start stall", 64'(bus.stall_exe), 64'd0);
      tick();
      bus.mtlo_exe  = 1'b0;
      bus.start_exe = 1'b0;
      chk("mt+start lo", 64'(bus.lo), 64'h0000_0055);
      chk("mt+start busy", 64'(bus.busy), 64'd0);
      bus.mtlo_exe = 1'b1;
      bus.srca_exe = 32'h0000_1234;
      tick();
      bus.mtlo_exe = 1'b0;

      // flush during BUSY cycle 10
`ifdef MULDIV_FAST_MUL_EN
      fl_op = MULDIV_DIVU;
`else
      fl_op = MULDIV_MULTU;
`endif
      bus.start_exe = 1'b1;
      bus.op_exe    = fl_op;
      bus.srca_exe  = 32'd3;
      bus.srcb_exe  = 32'd5;
      for (int c = 1; c <= 10; c++) tick();
      chk("flush busy c10", 64'(bus.busy), 64'd1);
      bus.flush_exe = 1'b1;
      bus.start_exe = 1'b0;
      #1;
      chk("flush stall c10", 64'(bus.stall_exe), 64'd1);
      tick();
      bus.flush_exe = 1'b0;
      chk("flush busy after", 64'(bus.busy), 64'd0);
      chk("flush stall after", 64'(bus.stall_exe), 64'd0);
      chk("flush lo kept", 64'(bus.lo), 64'h0000_1234);
      chk("flush hi kept", 64'(bus.hi), 64'h0000_CAFE);
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         if (bus.done !== 1'b0) seen++;
         tick();
      end
      chk("flush no done", 64'(seen), 64'd0);

      // MTHI while BUSY is ignored; operation still completes
      bus.start_exe = 1'b1;
      bus.op_exe    = MULDIV_DIVU;
      bus.srca_exe  = 32'd100;
      bus.srcb_exe  = 32'd7;
      for (int c = 1; c <= 5; c++) tick();
      bus.mthi_exe = 1'b1;
      bus.srca_exe = 32'hDEAD_BEEF;
      tick();
      bus.mthi_exe = 1'b0;
      chk("mthi in busy", 64'(bus.hi), 64'h0000_CAFE);
      for (int c = 7; c <= 34; c++) tick();
      chk("post-mthi done", 64'(bus.done), 64'd1);
      chk("post-mthi hi", 64'(bus.hi), 64'd2);
      chk("post-mthi lo", 64'(bus.lo), 64'd14);
      bus.start_exe = 1'b0;
      tick();

      // flush in SIGN (cycle 33): result discarded
      bus.start_exe = 1'b1;
      bus.op_exe    = MULDIV_DIVU;
      bus.srca_exe  = 32'd50;
      bus.srcb_exe  = 32'd3;
      for (int c = 1; c <= 33; c++) tick();
      chk("sign busy", 64'(bus.busy), 64'd1);
      bus.flush_exe = 1'b1;
      bus.start_exe = 1'b0;
      tick();
      bus.flush_exe = 1'b0;
      chk("sign flush busy", 64'(bus.busy), 64'd0);
      chk("sign flush done", 64'(bus.done), 64'd0);
      chk("sign flush hi", 64'(bus.hi), 64'd2);
      chk("sign flush lo", 64'(bus.lo), 64'd14);
      tick();
      chk("sign flush no done", 64'(bus.done), 64'd0);

      // reset mid-BUSY
      bus.start_exe = 1'b1;
      bus.op_exe    = MULDIV_DIVU;
      bus.srca_exe  = 32'd9;
      bus.srcb_exe  = 32'd2;
      for (int c = 1; c <= 8; c++) tick();
      rst = 1'b1;
      bus.start_exe = 1'b0;
      tick();
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst stall", 64'(bus.stall_exe), 64'd0);
      chk("rst hi", 64'(bus.hi), 64'd0);
      chk("rst lo", 64'(bus.lo), 64'd0);
      rst = 1'b0;
      tick();
      chk("rst no done", 64'(bus.done), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
